// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink
// OPB slave exposing C_NUM_REGS 32-bit software registers to the fabric as a
// flat bus with per-register update strobes. Single-cycle ack latency, at most
// one accepted access every two cycles.
// Optional macro OPB_REGBANK_ATOMIC_COMMIT_EN: writes land in shadow registers
// and reach user_data_out only when the commit word (index C_NUM_REGS) is
// written with bit 31 (LSB) set.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_1100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_11FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [31:0] C_INIT_VALUE = 32'h0
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst_n,
    input  logic [0:31]              OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:31]              OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:31]              Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]    user_wr_stb
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t state_reg, state_next;

    logic [31:0] addr, offset, wdata, rd_data;
    logic [29:0] word_idx;
    logic [3:0]  lane_en;      // lane_en[k] enables byte k counted from the LSB
    logic        lane_any;
    logic        in_range, reg_hit, commit_hit, hit, accept, wr_accept;
    logic        commit_fire;
    logic [31:0] sl_dbus_reg;
    logic        ack_reg;
    logic [32*C_NUM_REGS-1:0] vis_flat;   // value a read returns, per register
    logic        unused_ok;

    // Big-endian bus bit 0 is the numeric MSB, so plain assignment keeps values.
    assign addr     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign lane_en  = {OPB_BE[0], OPB_BE[1], OPB_BE[2], OPB_BE[3]};
    assign lane_any = |lane_en;

    assign offset   = addr - C_BASEADDR;
    assign word_idx = offset[31:2];
    assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign reg_hit  = in_range && (word_idx < 30'(C_NUM_REGS));
`ifdef OPB_REGBANK_ATOMIC_COMMIT_EN
    assign commit_hit = in_range && (word_idx == 30'(C_NUM_REGS));
`else
    assign commit_hit = 1'b0;
`endif
    assign hit         = OPB_select && (reg_hit || commit_hit);
    assign accept      = (state_reg == IDLE) && hit;
    assign wr_accept   = accept && !OPB_RNW;
    assign commit_fire = wr_accept && commit_hit && lane_en[0] && wdata[0];

    assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0]};

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  en);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    // State register: accept in IDLE, always return from ACK.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state_reg <= IDLE;
        else            state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (hit) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read mux over the visible register values; commit word and misses read 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_idx == 30'(i)) rd_data = vis_flat[32*i +: 32];
        end
    end

    // Ack and read data are registered on the accepting edge, zero otherwise.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack_reg     <= 1'b0;
            sl_dbus_reg <= '0;
        end else begin
            ack_reg     <= accept;
            sl_dbus_reg <= (accept && OPB_RNW && reg_hit) ? rd_data : 32'h0;
        end
    end

    assign Sl_xferAck = ack_reg;
    assign Sl_DBus    = sl_dbus_reg;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
            logic [31:0] out_reg;
            logic        stb_reg;
            logic        wr_sel;

            assign wr_sel = wr_accept && reg_hit && (word_idx == 30'(gi));
`ifdef OPB_REGBANK_ATOMIC_COMMIT_EN
            logic [31:0] shadow_reg;
            logic        dirty_reg;

            // Shadow captures byte writes; dirty marks it pending for commit.
            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    shadow_reg <= C_INIT_VALUE;
                    dirty_reg  <= 1'b0;
                end else if (wr_sel && lane_any) begin
                    shadow_reg <= byte_merge(shadow_reg, wdata, lane_en);
                    dirty_reg  <= 1'b1;
                end else if (commit_fire) begin
                    dirty_reg  <= 1'b0;
                end
            end

            // Commit copies pending shadows to the fabric and strobes them.
            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    out_reg <= C_INIT_VALUE;
                    stb_reg <= 1'b0;
                end else begin
                    stb_reg <= commit_fire && dirty_reg;
                    if (commit_fire && dirty_reg) out_reg <= shadow_reg;
                end
            end

            assign vis_flat[32*gi +: 32] = shadow_reg;
`else
            // Direct mode: byte writes go straight to the fabric output.
            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    out_reg <= C_INIT_VALUE;
                    stb_reg <= 1'b0;
                end else begin
                    stb_reg <= wr_sel && lane_any;
                    if (wr_sel) out_reg <= byte_merge(out_reg, wdata, lane_en);
                end
            end

            assign vis_flat[32*gi +: 32] = out_reg;
`endif
            assign user_data_out[32*gi +: 32] = out_reg;
            assign user_wr_stb[gi]            = stb_reg;
        end
    endgenerate

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink: directed cases plus
// randomized traffic compared every cycle against a behavioural model.
// Honours OPB_REGBANK_ATOMIC_COMMIT_EN when defined for the build.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h0100_1100;
    localparam logic [31:0] HIGH = 32'h0100_11FF;
    localparam logic [31:0] INIT = 32'hA5A5_0000;
    localparam int          N    = 4;
`ifdef OPB_REGBANK_ATOMIC_COMMIT_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   abus = '0;
    logic [3:0]    be = '0;
    logic [31:0]   wdat = '0;
    logic          rnw = 1'b1;
    logic          sel = 1'b0;
    logic          seq = 1'b0;
    logic [31:0]   sl_dbus;
    logic          xfer_ack, err_ack, retry, tout_sup;
    logic [127:0]  data_out;
    logic [3:0]    wr_stb;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_out [N];
    logic [31:0] m_sh  [N];
    bit          m_dirty [N];
    bit          m_ack;
    logic [31:0] m_dbus;
    logic [3:0]  m_stb;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .C_NUM_REGS  (N),
        .C_INIT_VALUE(INIT)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (wdat),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (xfer_ack),
        .Sl_errAck    (err_ack),
        .Sl_retry     (retry),
        .Sl_toutSup   (tout_sup),
        .user_data_out(data_out),
        .user_wr_stb  (wr_stb)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] e);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (e[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic [127:0] exp_data();
        logic [127:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = m_out[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i] = INIT; m_sh[i] = INIT; m_dirty[i] = 1'b0;
        end
        m_ack = 1'b0; m_dbus = '0; m_stb = '0;
    endtask

    // One clock edge of the specified behaviour: an ack never follows an ack.
    task automatic model_step();
        bit was_ack;
        int idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_ack = m_ack;
        m_ack = 1'b0; m_dbus = '0; m_stb = '0;
        if (was_ack || !sel || abus < BASE || abus > HIGH) return;
        idx = int'((abus - BASE) >> 2);
        if (idx < N) begin
            m_ack = 1'b1;
            if (rnw) begin
                m_dbus = ATOMIC ? m_sh[idx] : m_out[idx];
            end else if (be != 4'b0) begin
                if (ATOMIC) begin
                    m_sh[idx] = merge(m_sh[idx], wdat, be);
                    m_dirty[idx] = 1'b1;
                end else begin
                    m_out[idx] = merge(m_out[idx], wdat, be);
                    m_stb[idx] = 1'b1;
                end
            end
        end else if (ATOMIC && idx == N) begin
            m_ack = 1'b1;
            if (!rnw && be[0] && wdat[0]) begin
                for (int i = 0; i < N; i++) begin
                    if (m_dirty[i]) begin
                        m_out[i] = m_sh[i];
                        m_stb[i] = 1'b1;
                    end
                    m_dirty[i] = 1'b0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("xfer_ack", {127'b0, xfer_ack}, {127'b0, m_ack});
            check("sl_dbus", {96'b0, sl_dbus}, {96'b0, m_dbus});
            check("user_data_out", data_out, exp_data());
            check("user_wr_stb", {124'b0, wr_stb}, {124'b0, m_stb});
            check("tied_zero", {125'b0, err_ack, retry, tout_sup}, 128'b0);
        end
    end

    task automatic do_access(input bit r, input logic [31:0] a, input logic [3:0] e,
                             input logic [31:0] d, output logic [31:0] rd,
                             output bit acked, output logic [3:0] stb);
        @(negedge clk);
        sel = 1'b1; rnw = r; abus = a; be = e; wdat = d;
        @(negedge clk);
        acked = xfer_ack; rd = sl_dbus; stb = wr_stb;
        sel = 1'b0;
        $display("access %s addr=%h be=%b wdata=%h -> ack=%0d rdata=%h stb=%b",
                 r ? "RD" : "WR", a, e, d, acked, rd, stb);
    endtask

    logic [31:0] rd;
    bit          ak;
    logic [3:0]  st;
    int          ack_cnt;
    int          dbus_nz;

    initial begin
        #3 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_data", data_out, {4{INIT}});
        check("reset_ack", {127'b0, xfer_ack}, 128'b0);
        check("reset_dbus", {96'b0, sl_dbus}, 128'b0);

`ifndef OPB_REGBANK_ATOMIC_COMMIT_EN
        do_access(1'b0, BASE + 32'd8, 4'b1111, 32'hDEADBEEF, rd, ak, st);
        check("wr_ack", {127'b0, ak}, {127'b0, 1'b1});
        check("wr_stb", {124'b0, st}, {124'b0, 4'b0100});
        check("wr_data", {96'b0, data_out[95:64]}, {96'b0, 32'hDEADBEEF});
        @(negedge clk);
        check("wr_stb_drop", {124'b0, wr_stb}, 128'b0);
        do_access(1'b1, BASE + 32'd8, 4'b1111, 32'h0, rd, ak, st);
        check("rd_back", {96'b0, rd}, {96'b0, 32'hDEADBEEF});
        do_access(1'b0, BASE + 32'd8, 4'b0101, 32'h11223344, rd, ak, st);
        do_access(1'b1, BASE + 32'd8, 4'b1111, 32'h0, rd, ak, st);
        check("byte_merge", {96'b0, rd}, {96'b0, 32'hDE22BE44});
        do_access(1'b0, BASE + 32'd8, 4'b0000, 32'hFFFFFFFF, rd, ak, st);
        check("be0_ack", {127'b0, ak}, {127'b0, 1'b1});
        check("be0_stb", {124'b0, st}, 128'b0);
        check("be0_data", {96'b0, data_out[95:64]}, {96'b0, 32'hDE22BE44});
`else
        do_access(1'b0, BASE, 4'b1111, 32'd1, rd, ak, st);
        check("sh_wr0_stb", {124'b0, st}, 128'b0);
        do_access(1'b0, BASE + 32'd12, 4'b1111, 32'd3, rd, ak, st);
        check("sh_out_hold", data_out, {4{INIT}});
        do_access(1'b1, BASE, 4'b1111, 32'h0, rd, ak, st);
        check("sh_rd0", {96'b0, rd}, 128'd1);
        do_access(1'b1, BASE + 32'd12, 4'b1111, 32'h0, rd, ak, st);
        check("sh_rd3", {96'b0, rd}, 128'd3);
        do_access(1'b0, BASE + 32'd16, 4'b1111, 32'd1, rd, ak, st);
        check("commit_stb", {124'b0, st}, {124'b0, 4'b1001});
        check("commit_data", data_out, {32'd3, INIT, INIT, 32'd1});
        do_access(1'b0, BASE + 32'd16, 4'b1111, 32'd1, rd, ak, st);
        check("commit2_ack", {127'b0, ak}, {127'b0, 1'b1});
        check("commit2_stb", {124'b0, st}, 128'b0);
`endif

        // Out-of-bank read: never acked, bus stays quiet.
        ack_cnt = 0; dbus_nz = 0;
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h40; be = 4'b1111;
        repeat (16) begin
            @(negedge clk);
            if (xfer_ack) ack_cnt++;
            if (sl_dbus != 32'h0) dbus_nz++;
        end
        sel = 1'b0;
        check("miss_acks", 128'(ack_cnt), 128'd0);
        check("miss_dbus", 128'(dbus_nz), 128'd0);

        // Reset asserted during the ack cycle of a write.
        @(negedge clk);
        sel = 1'b1; rnw = 1'b0; abus = BASE + 32'd4; be = 4'b1111; wdat = 32'h12345678;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {127'b0, xfer_ack}, 128'b0);
        check("rst_mid_data", data_out, {4{INIT}});
        check("rst_mid_stb", {124'b0, wr_stb}, 128'b0);
        @(negedge clk);
        sel = 1'b0;
        rst_n = 1'b1;
        do_access(1'b1, BASE + 32'd4, 4'b1111, 32'h0, rd, ak, st);
        check("post_rst_ack", {127'b0, ak}, {127'b0, 1'b1});
        check("post_rst_rd", {96'b0, rd}, {96'b0, INIT});

        // Randomized traffic, including held select, misses and commit words.
        for (int c = 0; c < 600; c++) begin
            int r;
            @(negedge clk);
            sel  = ($urandom_range(0, 99) < 60);
            rnw  = $urandom_range(0, 1) == 1;
            be   = 4'($urandom_range(0, 15));
            wdat = $urandom;
            r    = $urandom_range(0, 9);
            case (r)
                6:       abus = BASE + 32'h40;
                7:       abus = BASE - 32'd4;
                8:       abus = HIGH + 32'd1;
                9:       abus = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
                default: abus = BASE + 32'(4 * r);
            endcase
        end
        @(negedge clk);
        sel = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised OPB slave holding `C_NUM_REGS` 32-bit software registers that the PowerPC writes and reads back, presented to the Simulink fabric as one flat output bus plus per-register update strobes. It replaces one-register-per-core instances in the XPS_ROACH_base peripheral set and sits on the OPB between the PPC bridge and the user design. An optional atomic-commit mode double-buffers the bank so multi-word settings reach the fabric in the same cycle.

## Interface
- `C_BASEADDR`, default 32'h01001100, first register byte address (4-byte aligned).
- `C_HIGHADDR`, default 32'h010011FF, last decoded byte address; must cover all registers plus the commit word.
- `C_OPB_AWIDTH`, default 32, OPB address width.
- `C_OPB_DWIDTH`, default 32, OPB data width (only 32 is supported).
- `C_NUM_REGS`, default 4, register count, range 1..32.
- `C_INIT_VALUE`, default 32'h0, reset value of every register.
- `OPB_Clk`  in  1  sole clock; OPB and user side share it.
- `OPB_Rst_n`  in  1  asynchronous, active-low reset.
- `OPB_ABus`  in  [0:31]  address, big-endian bit order.
- `OPB_BE`  in  [0:3]  byte enables; BE[0] selects DBus[0:7] (MSB byte).
- `OPB_DBus`  in  [0:31]  write data.
- `OPB_RNW`  in  1  1 = read, 0 = write.
- `OPB_select`  in  1  transfer request.
- `OPB_seqAddr`  in  1  ignored.
- `Sl_DBus`  out  [0:31]  read data; zero except in the ack cycle of a read.
- `Sl_xferAck`  out  1  one-cycle transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup`  out  1 each  tied 0.
- `user_data_out`  out  [32*C_NUM_REGS-1:0]  register i on bits [32i+31:32i].
- `user_wr_stb`  out  [C_NUM_REGS-1:0]  bit i pulses one cycle when register i's output value is updated by a write.

## Operation
- Decode: hit when `OPB_select` = 1 and `C_BASEADDR <= OPB_ABus <= C_HIGHADDR`. The word index is (ABus − BASEADDR) >> 2. Index < C_NUM_REGS selects register i. Index == C_NUM_REGS selects the commit word (only when the macro is enabled). Any other index is a miss: no ack, no state change, and the master times out.
- FSM has two states, IDLE and ACK. IDLE → ACK on a hit, ACK → IDLE unconditionally. A hit is accepted only in IDLE, so a held `OPB_select` gives at most one ack every two cycles.
- Write: on the IDLE→ACK edge, each byte of the target with its BE bit set takes the matching DBus byte. Bytes with BE = 0 hold their value.
- Read: in the ACK cycle, `Sl_DBus` carries the register contents, registered on the IDLE→ACK edge. The commit word reads as 0.
- Write with all BE = 0 is acked and changes nothing. No strobe is generated.
- Reset (any time, including mid-transfer): state IDLE, all registers and shadows = `C_INIT_VALUE`, `Sl_DBus` = 0, `Sl_xferAck` = 0, `user_wr_stb` = 0. An in-flight transfer is dropped without an ack.

## Timing
- Select/hit sampled at edge E, so `Sl_xferAck` = 1 during cycle E+1 only. Fixed latency is one cycle.
- A direct write is visible on `user_data_out` from cycle E+1. `user_wr_stb[i]` is high in cycle E+1 only.
- A committed write is visible from the cycle after the commit-word ack edge. All strobes for the committed registers pulse together in that cycle.
- `Sl_DBus` is registered and driven to 0 in every non-ack cycle, as the OPB wired-OR requires.

## Configuration
- `OPB_REGBANK_ATOMIC_COMMIT_EN` defined: register writes land in shadow registers, and reads return the shadow.
  - A write to the commit word with DBus[31] = 1 and BE[3] = 1 copies every shadow whose dirty flag is set to `user_data_out`. It pulses `user_wr_stb` for exactly those registers, then clears all dirty flags.
  - A commit with DBus[31] = 0 is acked and does nothing.
  - A write to a register in the same access as a commit is impossible, because only one access is accepted per two cycles.
- Undefined: no shadows exist and writes go straight to the outputs. The commit-word address is a miss.

## Test plan
- Reset, C_INIT_VALUE = 32'hA5A5_0000, C_NUM_REGS = 4 -> all of `user_data_out` = {4{32'hA5A50000}}, acks 0, `Sl_DBus` 0.
- Write 32'hDEADBEEF with BE = 4'b1111 to BASEADDR+8 (macro off) -> ack in the next cycle. Bits [95:64] = 32'hDEADBEEF, `user_wr_stb` = 4'b0100 for one cycle. Read back returns 32'hDEADBEEF in the ack cycle.
- Write 32'h11223344 with BE = 4'b0101 over 32'hDEADBEEF -> register = 32'hDE22BE44.
- Read BASEADDR+0x40 with C_NUM_REGS = 4 and macro off -> no `Sl_xferAck` for 16 cycles, and `Sl_DBus` stays 0.
- Macro on: write reg0 = 1 and reg3 = 3 -> outputs unchanged, reads return 1 and 3. Write 1 to BASEADDR+16 -> reg0 and reg3 update in the same cycle, `user_wr_stb` = 4'b1001. A second commit gives no strobes.
- Assert `OPB_Rst_n` low in the ack cycle of a write -> ack drops at once, registers return to `C_INIT_VALUE`, and the next access after release acks normally.
